// File: rtl/shared_bus_rr_arbiter_if.sv
// Handshake bundle between NREQ requesters, the round-robin arbiter and the shared consumer.
// The arbiter connects through the slave modport; the master modport is the requester/consumer side.
interface shared_bus_rr_arbiter_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NREQ  = 4
);
   localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]       in_valid;
   logic [NREQ*WIDTH-1:0] in_data;
   logic [NREQ-1:0]       in_last;
   logic [NREQ-1:0]       in_ready;
   logic                  out_valid;
   logic [WIDTH-1:0]      out_data;
   logic                  out_last;
   logic [IDW-1:0]        out_id;
   logic                  out_ready;
   logic                  busy;

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last, out_id, busy
   );

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last, out_id, busy
   );
endinterface

// File: rtl/shared_bus_rr_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit stream port among NREQ requesters.
// A grant is held for a whole burst (in_last or MAX_BURST beats), then priority rotates.
module shared_bus_rr_arbiter #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned NREQ      = 4,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   shared_bus_rr_arbiter_if.slave bus
);
   localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned SW  = IDW + 1;
   localparam int unsigned CW  = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_e;

   state_e         state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [IDW-1:0] grant_q, grant_d;
   logic [IDW-1:0] out_id_q, out_id_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           busy_q, busy_d;

   logic             granted_c;
   logic             g_valid_c;
   logic             g_last_c;
   logic [WIDTH-1:0] g_data_c;
   logic             last_c;
   logic             beat_c;
   logic [NREQ-1:0]  ready_c;
   logic [NREQ-1:0]  rot_c;
   logic [SW-1:0]    win_off_c;
   logic [SW-1:0]    win_sum_c;
   logic [IDW-1:0]   win_idx_c;
   logic             win_found_c;
   logic [IDW-1:0]   ptr_next_c;

   // A reset cycle must never accept a beat, so the grant is masked while rst is high.
   assign granted_c = (state_q == ST_GRANT) && !rst;

   // Mux of the granted requester's stream.
   always_comb begin
      g_valid_c = 1'b0;
      g_last_c  = 1'b0;
      g_data_c  = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant_q == IDW'(i)) begin
            g_valid_c = bus.in_valid[i];
            g_last_c  = bus.in_last[i];
            g_data_c  = bus.in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign last_c = g_last_c || (cnt_q == CW'(MAX_BURST - 1));
   assign beat_c = granted_c && g_valid_c && bus.out_ready;

   always_comb begin
      ready_c = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (granted_c && (grant_q == IDW'(i))) begin
            ready_c[i] = bus.out_ready;
         end
      end
   end

   // Rotate requests so bit 0 is the pointer position; the lowest set bit wins.
   always_comb begin
      rot_c       = NREQ'({bus.in_valid, bus.in_valid} >> ptr_q);
      win_off_c   = '0;
      win_found_c = |bus.in_valid;
      for (int i = int'(NREQ) - 1; i >= 0; i--) begin
         if (rot_c[i]) begin
            win_off_c = SW'(i);
         end
      end
      win_sum_c = {1'b0, ptr_q} + win_off_c;
      if (win_sum_c >= SW'(NREQ)) begin
         win_sum_c = win_sum_c - SW'(NREQ);
      end
      win_idx_c = win_sum_c[IDW-1:0];
   end

   assign ptr_next_c = (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + IDW'(1);

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (win_found_c) begin
               grant_d = win_idx_c;
               cnt_d   = '0;
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (beat_c) begin
               if (last_c) begin
                  state_d = ST_IDLE;
                  ptr_d   = ptr_next_c;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d   = (state_d == ST_GRANT);
      out_id_d = busy_d ? grant_d : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         grant_q  <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         out_id_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         grant_q  <= grant_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         out_id_q <= out_id_d;
      end
   end

   assign bus.in_ready  = ready_c;
   assign bus.out_valid = granted_c && g_valid_c;
   assign bus.out_data  = granted_c ? g_data_c : '0;
   assign bus.out_last  = granted_c && last_c;
   assign bus.out_id    = out_id_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_shared_bus_rr_arbiter.sv
// Directed bench for shared_bus_rr_arbiter: reset, single burst, rotation, forced cut,
// backpressure and reset mid-burst, with hand-computed expectations.
module tb_shared_bus_rr_arbiter;
   localparam int unsigned WIDTH     = 8;
   localparam int unsigned NREQ      = 4;
   localparam int unsigned MAX_BURST = 4;

   logic clk = 1'b0;
   logic rst;
   int   vectors     = 0;
   int   miscompares = 0;

   shared_bus_rr_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

   shared_bus_rr_arbiter #(
      .WIDTH    (WIDTH),
      .NREQ     (NREQ),
      .MAX_BURST(MAX_BURST)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Forced-cut scenario, cycle by cycle.
   logic       t4_ov   [11] = '{0, 1, 1, 1, 1, 0, 1, 0, 1, 1, 0};
   logic [1:0] t4_id   [11] = '{0, 1, 1, 1, 1, 0, 3, 0, 1, 1, 0};
   logic [7:0] t4_data [11] = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h00,
                                8'h3A, 8'h00, 8'h14, 8'h15, 8'h00};
   logic       t4_last [11] = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0};

   // Backpressure scenario, cycle by cycle.
   logic       t5_ordy [7] = '{0, 0, 0, 0, 1, 1, 1};
   logic       t5_ov   [7] = '{0, 1, 1, 1, 1, 1, 0};
   logic [7:0] t5_data [7] = '{8'h00, 8'h50, 8'h50, 8'h50, 8'h50, 8'h51, 8'h00};
   logic       t5_last [7] = '{0, 0, 0, 0, 0, 1, 0};
   logic [3:0] t5_rdy  [7] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step_in();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
      bus.in_valid[i]              = v;
      bus.in_data[i*WIDTH +: WIDTH] = d;
      bus.in_last[i]               = l;
   endtask

   task automatic idle_all();
      bus.in_valid = '0;
      bus.in_data  = '0;
      bus.in_last  = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int j;
      logic done3;

      // Reset then idle
      rst           = 1'b1;
      bus.out_ready = 1'b0;
      idle_all();
      step_in();
      step_in();
      sample();
      chk("rst_ready", bus.in_ready, 0);
      chk("rst_valid", bus.out_valid, 0);
      step_in();
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         sample();
         chk("idle_outs", {bus.out_valid, bus.in_ready, bus.busy, bus.out_id}, 0);
         step_in();
      end

      // Single requester, two-beat burst
      set_req(2, 1'b1, 8'hA1, 1'b0);
      bus.out_ready = 1'b1;
      sample();
      chk("t2_pre_valid", bus.out_valid, 0);
      step_in();
      sample();
      chk("t2_b1_valid", bus.out_valid, 1);
      chk("t2_b1_id", bus.out_id, 2);
      chk("t2_b1_data", bus.out_data, 8'hA1);
      chk("t2_b1_last", bus.out_last, 0);
      chk("t2_b1_ready", bus.in_ready, 4'b0100);
      chk("t2_b1_busy", bus.busy, 1);
      step_in();
      set_req(2, 1'b1, 8'hA2, 1'b1);
      sample();
      chk("t2_b2_data", bus.out_data, 8'hA2);
      chk("t2_b2_last", bus.out_last, 1);
      chk("t2_b2_valid", bus.out_valid, 1);
      step_in();
      set_req(2, 1'b0, 8'h00, 1'b0);
      sample();
      chk("t2_gap_busy", bus.busy, 0);
      chk("t2_gap_valid", bus.out_valid, 0);

      // Round-robin rotation, pointer restarted by reset
      step_in();
      rst = 1'b1;
      sample();
      step_in();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'(8'h30 + i), 1'b1);
      sample();
      chk("t3_k0_busy", bus.busy, 0);
      for (int k = 1; k < 12; k++) begin
         step_in();
         sample();
         if (k % 2 == 1) begin
            chk("t3_beat_busy", bus.busy, 1);
            chk("t3_beat_id", bus.out_id, ((k - 1) / 2) % 4);
            chk("t3_beat_data", bus.out_data, 8'h30 + ((k - 1) / 2) % 4);
         end else begin
            chk("t3_gap_busy", bus.busy, 0);
            chk("t3_gap_valid", bus.out_valid, 0);
         end
      end
      step_in();
      idle_all();
      sample();
      chk("t3_end_busy", bus.busy, 0);

      // Forced burst cut at MAX_BURST, requester 3 interleaves
      step_in();
      rst = 1'b1;
      sample();
      step_in();
      rst   = 1'b0;
      j     = 0;
      done3 = 1'b0;
      for (int c = 0; c < 11; c++) begin
         if (c > 0) step_in();
         set_req(1, j < 6, 8'(8'h10 + j), j == 5);
         set_req(3, !done3, 8'h3A, 1'b1);
         sample();
         chk("t4_valid", bus.out_valid, t4_ov[c]);
         chk("t4_busy", bus.busy, t4_ov[c]);
         chk("t4_data", bus.out_data, t4_data[c]);
         chk("t4_last", bus.out_last, t4_last[c]);
         if (t4_ov[c]) chk("t4_id", bus.out_id, t4_id[c]);
         if (bus.in_valid[1] && bus.in_ready[1]) j++;
         if (bus.in_valid[3] && bus.in_ready[3]) done3 = 1'b1;
      end
      step_in();
      idle_all();

      // Backpressure on requester 0 (pointer is 2, wraps to 0)
      j = 0;
      for (int c = 0; c < 7; c++) begin
         if (c > 0) step_in();
         bus.out_ready = t5_ordy[c];
         set_req(0, j < 2, 8'(8'h50 + j), j == 1);
         sample();
         chk("t5_valid", bus.out_valid, t5_ov[c]);
         chk("t5_data", bus.out_data, t5_data[c]);
         chk("t5_last", bus.out_last, t5_last[c]);
         chk("t5_ready", bus.in_ready, t5_rdy[c]);
         if (bus.in_valid[0] && bus.in_ready[0]) j++;
      end
      step_in();
      idle_all();
      bus.out_ready = 1'b1;

      // Reset in the middle of a 4-beat burst from requester 2
      j = 0;
      set_req(2, 1'b1, 8'h60, 1'b0);
      sample();
      chk("t6_c0_valid", bus.out_valid, 0);
      if (bus.in_valid[2] && bus.in_ready[2]) j++;
      for (int c = 1; c < 3; c++) begin
         step_in();
         set_req(2, 1'b1, 8'(8'h60 + j), j == 3);
         sample();
         chk("t6_beat_id", bus.out_id, 2);
         chk("t6_beat_data", bus.out_data, 8'h60 + c - 1);
         if (bus.in_valid[2] && bus.in_ready[2]) j++;
      end
      step_in();
      rst = 1'b1;
      set_req(2, 1'b1, 8'(8'h60 + j), j == 3);
      set_req(0, 1'b1, 8'h70, 1'b1);
      sample();
      chk("t6_rst_ready", bus.in_ready, 0);
      chk("t6_rst_valid", bus.out_valid, 0);
      step_in();
      rst = 1'b0;
      sample();
      chk("t6_post_busy", bus.busy, 0);
      chk("t6_post_valid", bus.out_valid, 0);
      step_in();
      sample();
      chk("t6_regrant_id", bus.out_id, 0);
      chk("t6_regrant_data", bus.out_data, 8'h70);
      chk("t6_regrant_last", bus.out_last, 1);
      chk("t6_regrant_ready", bus.in_ready, 4'b0001);
      step_in();
      idle_all();
      sample();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/shared_bus_rr_arbiter.md
Name: shared_bus_rr_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit downstream resource port among NREQ requesters.
- Each requester presents a valid/ready stream with a last marker.
- The arbiter locks a grant for a whole burst (until last, or until MAX_BURST beats), then rotates priority.
- Sits between parameterised producer blocks and a single shared consumer, for example a display/log sink or a memory write port.

Parameters:
- WIDTH, 8, data width of every requester and of the output port.
- NREQ, 4, number of requesters; legal range 2..16.
- MAX_BURST, 4, maximum beats per grant before forced rotation; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  NREQ  per-requester beat valid.
- in_data  input  NREQ*WIDTH  per-requester data; requester i occupies bits [i*WIDTH +: WIDTH].
- in_last  input  NREQ  per-requester end-of-burst marker.
- in_ready  output  NREQ  per-requester beat accepted when in_valid[i]&&in_ready[i].
- out_valid  output  1  beat valid to shared resource.
- out_data  output  WIDTH  beat data.
- out_last  output  1  end of burst as seen downstream; forced high on the MAX_BURST-th beat.
- out_id  output  IDW  index of granted requester, where IDW = max(1, clog2(NREQ)).
- out_ready  input  1  shared resource accepts a beat when out_valid&&out_ready.
- busy  output  1  high while a grant is held.

Behaviour:
- Reset (rst=1 at a clk edge) produces the following, regardless of state, including mid-burst:
  - state=IDLE, priority pointer=0, beat count=0, grant index=0.
  - out_valid=0, in_ready=0, out_last=0, out_id=0, out_data=0, busy=0.
  - A partially transferred burst is abandoned. No beat is accepted on a reset cycle.
- State IDLE:
  - All in_ready=0, out_valid=0, busy=0.
  - If any in_valid is high, the winner is the first set bit searching from pointer upward, with wrap-around modulo NREQ.
  - At the clk edge: grant index := winner, beat count := 0, state := GRANT.
  - Arbitration latency is 1 cycle, from in_valid high to out_valid.
- State GRANT (g = grant index):
  - busy=1 and out_id=g.
  - Output signals are combinational from the granted requester:
    - out_valid = in_valid[g].
    - out_data = in_data[g].
    - out_last = in_last[g] OR (beat count == MAX_BURST-1).
  - in_ready[g] = out_ready. All other in_ready = 0.
  - A beat transfers when out_valid && out_ready. Each transfer increments beat count.
  - A transfer with out_last=1 ends the grant: state := IDLE, pointer := (g+1) mod NREQ, beat count := 0.
  - A forced-last burst (MAX_BURST reached without in_last) ends the grant identically. The requester's remaining beats compete again.
  - If in_valid[g] drops mid-burst, the grant is held (no timeout) and out_valid=0.
- There is a 1 idle cycle between bursts (IDLE state). Maximum throughput is MAX_BURST/(MAX_BURST+1) under contention.
- Requests arriving while in GRANT are ignored until IDLE. Priority is fair: every requester waits at most NREQ-1 bursts.
- When out_ready=0, the data presented is held stable because the granted requester must hold its beat. The arbiter adds no buffering.
- In IDLE, out_data and out_last are driven to 0.
- The beat counter has width clog2(MAX_BURST+1) and never exceeds MAX_BURST-1 while in GRANT.
- MAX_BURST=1 means every beat has out_last=1 and grants rotate after each beat.

Test Plan:
- Reset then idle: rst high 2 cycles, all in_valid=0 for 10 cycles -> out_valid=0, in_ready=0, busy=0, out_id=0 throughout.
- Single requester:
  - Stimulus: in_valid[2]=1, data 0xA1,0xA2 with last on the 2nd beat, out_ready=1.
  - Response: out_valid rises 1 cycle after in_valid. out_id=2. out_data 0xA1 then 0xA2 with out_last=1 on 0xA2. Then busy=0 for 1 cycle.
- Round-robin rotation:
  - Stimulus: all 4 requesters valid continuously, single-beat bursts (last=1), out_ready=1.
  - Response: out_id sequence 0,1,2,3,0,1 with each beat separated by one IDLE cycle.
- Forced burst cut:
  - Stimulus: MAX_BURST=4, requester 1 sends 6 beats 0x10..0x15 with last only on 0x15, requester 3 also valid.
  - Response: beats 0x10..0x13 are sent with out_last=1 on 0x13, then out_id=3 for its burst, then requester 1 resumes with 0x14,0x15.
- Backpressure:
  - Stimulus: during a grant to requester 0, hold out_ready=0 for 3 cycles.
  - Response: in_ready[0]=0 and out_data stays constant, the beat count does not advance, and the transfer completes on the first cycle out_ready=1.
- Reset mid-burst:
  - Stimulus: assert rst after the 2nd beat of a 4-beat burst from requester 2, with requesters 0 and 2 valid afterwards.
  - Response: the next cycle has busy=0. After reset the first grant goes to requester 0 (pointer=0), not requester 2.
